// File: rtl/posit_mult_pipe.sv
// rtl/posit_mult_pipe.sv - pipelined posit fraction/scale multiplier core
//
// Multiplies two decoded posit operands (hidden-bit-free fraction, signed
// scale, NaR/zero/sign flags) and returns the normalised product with a
// valid/ready handshake on both sides.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid / in_ready      operand-pair handshake
//   fraction_i1/2            FRAC_W-bit fractions, hidden bit excluded
//   scale_i1/2               SCALE_W-bit signed scales
//   NaR_i1/2, zero_i1/2, sign_i1/2   operand flags
//   out_valid / out_ready    result handshake
//   fraction_o               2*FRAC_W+1-bit normalised fraction, hidden bit excluded
//   scale_o                  SCALE_W+1-bit signed product scale
//   NaR_o, zero_o, sign_o    result flags
//
// Build option: define POSIT_MULT_OUT_REG_EN to add a second register stage
// (S2) on the output; latency becomes 2, throughput stays 1 result/cycle.

module posit_mult_pipe #(
  parameter int FRAC_W  = 4,
  parameter int SCALE_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FRAC_W-1:0]    fraction_i1,
  input  logic [FRAC_W-1:0]    fraction_i2,
  input  logic [SCALE_W-1:0]   scale_i1,
  input  logic [SCALE_W-1:0]   scale_i2,
  input  logic                 NaR_i1,
  input  logic                 zero_i1,
  input  logic                 sign_i1,
  input  logic                 NaR_i2,
  input  logic                 zero_i2,
  input  logic                 sign_i2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*FRAC_W:0]    fraction_o,
  output logic [SCALE_W:0]     scale_o,
  output logic                 NaR_o,
  output logic                 zero_o,
  output logic                 sign_o
);

  localparam int PW = 2*FRAC_W + 2;   // raw product width
  localparam int FW = 2*FRAC_W + 1;   // output fraction width
  localparam int SW = SCALE_W + 1;    // output scale width
  localparam int RW = FW + SW + 3;    // packed result {NaR, zero, sign, scale, fraction}

  // ---------------------------------------------------------------------
  // Combinational multiply / normalise
  // ---------------------------------------------------------------------
  logic [PW-1:0] prod;
  logic [SW-1:0] scale_sum;
  logic          nar_c;
  logic          zero_c;
  logic          sign_c;
  logic [SW-1:0] scale_c;
  logic [FW-1:0] frac_c;
  logic [RW-1:0] res_c;

  always_comb begin
    prod      = PW'({1'b1, fraction_i1}) * PW'({1'b1, fraction_i2});
    // Sign-extended add; SCALE_W+1 bits always holds the sum plus the
    // normalisation carry, so no saturation is needed.
    scale_sum = {scale_i1[SCALE_W-1], scale_i1} + {scale_i2[SCALE_W-1], scale_i2};
    nar_c     = NaR_i1 | NaR_i2;
    zero_c    = !nar_c && (zero_i1 || zero_i2);
    sign_c    = 1'b0;
    scale_c   = '0;
    frac_c    = '0;
    // Special results carry no payload: NaR and zero force sign/scale/fraction to 0.
    if (!nar_c && !zero_c) begin
      sign_c = sign_i1 ^ sign_i2;
      // The product of two [1,2) mantissas lies in [1,4); a set MSB means
      // it reached [2,4) and the binary point moves one place.
      if (prod[PW-1]) begin
        frac_c  = prod[FW-1:0];
        scale_c = scale_sum + SW'(1);
      end else begin
        frac_c  = {prod[FW-2:0], 1'b0};
        scale_c = scale_sum;
      end
    end
    res_c = {nar_c, zero_c, sign_c, scale_c, frac_c};
  end

  // ---------------------------------------------------------------------
  // Stage S1
  // ---------------------------------------------------------------------
  logic          s1_valid_q, s1_valid_d;
  logic [RW-1:0] s1_data_q,  s1_data_d;
  logic          s1_dn_ready;   // whatever follows S1 can take its content
  logic [RW-1:0] out_data;

  // S1 refills whenever it is empty or its content leaves this cycle; this
  // depends only on registered state and out_ready, never on in_valid.
  assign in_ready = !s1_valid_q || s1_dn_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = res_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

`ifdef POSIT_MULT_OUT_REG_EN
  // ---------------------------------------------------------------------
  // Optional output stage S2
  // ---------------------------------------------------------------------
  logic          s2_valid_q, s2_valid_d;
  logic [RW-1:0] s2_data_q,  s2_data_d;
  logic          s2_ready;

  assign s2_ready    = !s2_valid_q || out_ready;
  assign s1_dn_ready = s2_ready;

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
`else
  assign s1_dn_ready = out_ready;
  assign out_valid   = s1_valid_q;
  assign out_data    = s1_data_q;
`endif

  assign {NaR_o, zero_o, sign_o, scale_o, fraction_o} = out_data;

endmodule

// File: tb/tb_posit_mult_pipe.sv
// tb/tb_posit_mult_pipe.sv - scoreboard testbench for posit_mult_pipe

module tb_posit_mult_pipe;

  localparam int F  = 4;
  localparam int S  = 6;
  localparam int FW = 2*F + 1;
  localparam int SW = S + 1;
`ifdef POSIT_MULT_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic          nar;
    logic          zero;
    logic          sign;
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [F-1:0]  f1, f2;
  logic [S-1:0]  sc1, sc2;
  logic          n1, z1, g1, n2, z2, g2;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] fraction_o;
  logic [SW-1:0] scale_o;
  logic          NaR_o, zero_o, sign_o;
  res_t          out_vec;

  assign out_vec = {NaR_o, zero_o, sign_o, scale_o, fraction_o};

  always #5 clk = ~clk;

  posit_mult_pipe #(.FRAC_W(F), .SCALE_W(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .fraction_i1(f1), .fraction_i2(f2),
    .scale_i1(sc1), .scale_i2(sc2),
    .NaR_i1(n1), .zero_i1(z1), .sign_i1(g1),
    .NaR_i2(n2), .zero_i2(z2), .sign_i2(g2),
    .out_valid(out_valid), .out_ready(out_ready),
    .fraction_o(fraction_o), .scale_o(scale_o),
    .NaR_o(NaR_o), .zero_o(zero_o), .sign_o(sign_o)
  );

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mantissas as integers in [2^F, 2^(F+1)), product in
  // [2^(2F), 2^(2F+2)); strip the leading one and express the remainder in
  // 2F+1 fraction bits.
  function automatic res_t model(int a, int b, int sa, int sb,
                                 bit na, bit za, bit ga, bit nb, bit zb, bit gb);
    res_t r;
    int   p;
    r = '0;
    if (na || nb) begin
      r.nar = 1'b1;
    end else if (za || zb) begin
      r.zero = 1'b1;
    end else begin
      p = ((1 << F) + a) * ((1 << F) + b);
      if (p >= (1 << (2*F + 1))) begin
        r.frac  = FW'(p - (1 << (2*F + 1)));
        r.scale = SW'(sa + sb + 1);
      end else begin
        r.frac  = FW'((p - (1 << (2*F))) * 2);
        r.scale = SW'(sa + sb);
      end
      r.sign = ga ^ gb;
    end
    return r;
  endfunction

  // Monitor: at each falling edge, a result with out_valid && out_ready is
  // transferred on the coming rising edge, so it is popped and compared now.
  bit   held = 1'b0;
  res_t held_v;
  res_t e;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        chk("stall_data_held", 32'(out_vec), 32'(held_v));
      end
      if (!in_ready) chk("in_ready_low_only_if_stalled", 32'(out_valid && !out_ready), 32'd1);
`ifndef POSIT_MULT_OUT_REG_EN
      if (out_valid && !out_ready) chk("in_ready_low_when_stalled", 32'(in_ready), 32'd0);
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(out_vec), 32'h0 - 1);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(out_vec), 32'(e));
        end
      end
      held   = out_valid && !out_ready;
      held_v = out_vec;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the edge that took the pair,
  // leaving in_valid high so consecutive calls go back-to-back.
  task automatic send(logic [F-1:0] a, logic [F-1:0] b, logic [S-1:0] sa, logic [S-1:0] sb,
                      bit na, bit za, bit ga, bit nb, bit zb, bit gb);
    f1 = a; f2 = b; sc1 = sa; sc2 = sb;
    n1 = na; z1 = za; g1 = ga; n2 = nb; z2 = zb; g2 = gb;
    in_valid = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(int'(a), int'(b), int'($signed(sa)), int'($signed(sb)),
                              na, za, ga, nb, zb, gb));
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(F'($urandom), F'($urandom), S'($urandom), S'($urandom),
         $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, 1'($urandom),
         $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, 1'($urandom));
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  lat;
  bit  done;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    f1 = '0; f2 = '0; sc1 = '0; sc2 = '0;
    n1 = 0; z1 = 0; g1 = 0; n2 = 0; z2 = 0; g2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_vec), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // 1.5 * 1.5 = 2.25 -> normalised 1.125, scale 3 + -1 + 1
    out_ready = 1'b1;
    send(4'b1000, 4'b1000, 6'd3, 6'b111111, 0, 0, 0, 0, 0, 1);
    in_valid = 1'b0;
    wait_out(lat);
    chk("latency", 32'(lat), 32'(LAT));
    chk("basic_frac", 32'(fraction_o), 32'b001000000);
    chk("basic_scale", 32'(scale_o), 32'd3);
    chk("basic_sign", 32'(sign_o), 32'd1);
    drain();

    // Minimum scales: 1.0 * 1.0, scale -64
    send(4'd0, 4'd0, 6'b100000, 6'b100000, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("minscale_frac", 32'(fraction_o), 32'd0);
    chk("minscale_scale", 32'(scale_o), 32'(7'b1000000));
    drain();

    // NaR beats zero and clears the payload
    send(4'd5, 4'd7, 6'd10, 6'b111101, 1, 0, 1, 0, 1, 0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("nar_flag", 32'(NaR_o), 32'd1);
    chk("nar_payload", 32'({zero_o, sign_o, scale_o, fraction_o}), 32'd0);
    drain();

    // 8 back-to-back pairs with the consumer stalled for cycles 3-5
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 16; c++) begin
          out_ready = !(c >= 3 && c <= 5);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while a result is held: it must never appear
    out_ready = 1'b0;
    send_rand();
    in_valid = 1'b0;
    wait_out(lat);
    chk("held_before_reset", 32'(out_valid), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("reset_clears_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("flushed_stays_empty", 32'(out_valid), 32'd0);

    // Random traffic with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          send_rand();
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = $urandom_range(0, 3) != 0;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
